// File: rtl/somador_serial_pkg.sv
// rtl/somador_serial_pkg.sv - shared state codes and sizing helper for the serial adder
package somador_serial_pkg;

  // FSM state codes, fixed 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Ceiling log2, used to size the bit counter
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/somador_serial_if.sv
// rtl/somador_serial_if.sv - operand/result handshake bundle of the serial adder
interface somador_serial_if #(
  parameter int WIDTH = 4
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C_in;
  logic [WIDTH-1:0] S;
  logic             C_out;
  logic             V;
  logic             busy;
  logic             done;

  // Requester side: issues operands, observes results
  modport master (
    output start, A, B, C_in,
    input  S, C_out, V, busy, done
  );

  // Adder side: consumes operands, produces results
  modport slave (
    input  start, A, B, C_in,
    output S, C_out, V, busy, done
  );

endinterface

// File: rtl/somador_serial_completo_1bit.sv
// rtl/somador_serial_completo_1bit.sv - combinational 1-bit full adder
module somador_completo_1bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c_in,
  output logic o_s,
  output logic o_c_out
);

  assign o_s     = i_a ^ i_b ^ i_c_in;
  assign o_c_out = (i_a & i_b) | (i_c_in & (i_a ^ i_b));

endmodule

// File: rtl/somador_serial.sv
// rtl/somador_serial.sv - bit-serial adder, LSB first, one full adder, start/done handshake
module somador_serial
  import somador_serial_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  somador_serial_if.slave  bus
);

  localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_s;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_c_msb;
  logic             r_c_out;
  logic             r_v;
  logic             r_busy;
  logic             r_done;
  logic             w_fa_s;
  logic             w_fa_c;
  logic             w_last;
  logic             w_pre_msb;

  somador_completo_1bit u_fa (
    .i_a     (r_a_sr[0]),
    .i_b     (r_b_sr[0]),
    .i_c_in  (r_carry),
    .o_s     (w_fa_s),
    .o_c_out (w_fa_c)
  );

  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  assign w_pre_msb = (r_cnt == CW'(WIDTH - 2));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic: accept in IDLE, run WIDTH bit-steps, one DONE cycle
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start) w_state_next = ST_SHIFT;
      ST_SHIFT: if (w_last)    w_state_next = ST_DONE;
      ST_DONE:                 w_state_next = ST_IDLE;
      default:                 w_state_next = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, serial add, result commit at the final bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_res   <= '0;
      r_s     <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_c_msb <= 1'b0;
      r_c_out <= 1'b0;
      r_v     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a_sr  <= bus.A;
            r_b_sr  <= bus.B;
            r_carry <= bus.C_in;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_res   <= {w_fa_s, r_res[WIDTH-1:1]};
          r_carry <= w_fa_c;
          // Carry into the MSB position, needed for signed overflow
          if (w_pre_msb) r_c_msb <= w_fa_c;
          if (w_last) begin
            r_s     <= {w_fa_s, r_res[WIDTH-1:1]};
            r_c_out <= w_fa_c;
            r_v     <= w_fa_c ^ r_c_msb;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_done <= 1'b0;
        end
        default: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign bus.S     = r_s;
  assign bus.C_out = r_c_out;
  assign bus.V     = r_v;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;

endmodule

// File: tb/tb_somador_serial.sv
// tb/tb_somador_serial.sv - self-checking bench for somador_serial
module tb_somador_serial;

  localparam int WIDTH = 4;
  localparam int TMO   = 20;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  somador_serial_if #(.WIDTH(WIDTH)) bus ();

  somador_serial #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [WIDTH-1:0] exp_s;
  logic             exp_c;
  logic             exp_v;

  // Reference: plain unsigned and signed arithmetic on the operands
  task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
    int usum;
    int sa;
    int sb;
    int ssum;
    usum  = int'(a) + int'(b) + int'(cin);
    exp_s = WIDTH'(usum % (1 << WIDTH));
    exp_c = (usum >= (1 << WIDTH));
    sa    = a[WIDTH-1] ? int'(a) - (1 << WIDTH) : int'(a);
    sb    = b[WIDTH-1] ? int'(b) - (1 << WIDTH) : int'(b);
    ssum  = sa + sb + int'(cin);
    exp_v = (ssum > (1 << (WIDTH-1)) - 1) || (ssum < -(1 << (WIDTH-1)));
  endtask

  task automatic check_outputs(input string tag);
    n_cmp++;
    if (bus.S !== exp_s) begin
      n_bad++;
      $display("FAIL %s S got=%0d exp=%0d", tag, bus.S, exp_s);
    end
    n_cmp++;
    if (bus.C_out !== exp_c) begin
      n_bad++;
      $display("FAIL %s C_out got=%b exp=%b", tag, bus.C_out, exp_c);
    end
    n_cmp++;
    if (bus.V !== exp_v) begin
      n_bad++;
      $display("FAIL %s V got=%b exp=%b", tag, bus.V, exp_v);
    end
  endtask

  // One full operation: latency, busy length, results
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input string tag);
    int lat;
    int busy_cnt;
    bit got;
    @(negedge clk);
    bus.A = a; bus.B = b; bus.C_in = cin; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.A = WIDTH'($urandom); bus.B = WIDTH'($urandom); bus.C_in = 1'($urandom);
    lat = 0; busy_cnt = 0; got = 0;
    for (int n = 0; n < TMO; n++) begin
      if (bus.done) begin
        lat = n; got = 1;
        break;
      end
      if (bus.busy) busy_cnt++;
      @(negedge clk);
    end
    model(a, b, cin);
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL %s done_timeout got=0 exp=1", tag);
    end else begin
      n_cmp++;
      if (lat != WIDTH) begin
        n_bad++;
        $display("FAIL %s latency got=%0d exp=%0d", tag, lat, WIDTH);
      end
      n_cmp++;
      if (busy_cnt != WIDTH) begin
        n_bad++;
        $display("FAIL %s busy_cycles got=%0d exp=%0d", tag, busy_cnt, WIDTH);
      end
      n_cmp++;
      if (bus.busy !== 1'b0) begin
        n_bad++;
        $display("FAIL %s busy_at_done got=%b exp=0", tag, bus.busy);
      end
      check_outputs(tag);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_s = '0; exp_c = 1'b0; exp_v = 1'b0;
    check_outputs("reset");
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset busy got=%b exp=0", bus.busy);
    end
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset done got=%b exp=0", bus.done);
    end
  endtask

  task automatic test_directed();
    run_op(4'd5, 4'd3, 1'b0, "5p3");
    n_cmp++;
    if ({bus.S, bus.C_out, bus.V} !== {4'd8, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL 5p3_const got=%0d/%b/%b exp=8/0/1", bus.S, bus.C_out, bus.V);
    end
    run_op(4'd7, 4'd9, 1'b0, "7p9");
    run_op(4'd15, 4'd15, 1'b1, "max");
    run_op(4'd0, 4'd0, 1'b0, "zero");
  endtask

  task automatic test_ignore_start();
    logic [WIDTH-1:0] old_s;
    logic old_c;
    logic old_v;
    int dones;
    old_s = exp_s; old_c = exp_c; old_v = exp_v;
    @(negedge clk);
    bus.A = 4'd2; bus.B = 4'd1; bus.C_in = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.A = 4'd0; bus.B = 4'd0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    exp_s = old_s; exp_c = old_c; exp_v = old_v;
    check_outputs("hold_midop");
    dones = 0;
    for (int n = 0; n < 12; n++) begin
      if (bus.done) dones++;
      @(negedge clk);
    end
    n_cmp++;
    if (dones != 1) begin
      n_bad++;
      $display("FAIL ignore done_count got=%0d exp=1", dones);
    end
    model(4'd2, 4'd1, 1'b0);
    check_outputs("ignore_2p1");
  endtask

  task automatic test_reset_mid();
    int dones;
    @(negedge clk);
    bus.A = 4'd6; bus.B = 4'd5; bus.C_in = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_s = '0; exp_c = 1'b0; exp_v = 1'b0;
    check_outputs("async_rst");
    n_cmp++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_bad++;
      $display("FAIL async_rst busy_done got=%b%b exp=00", bus.busy, bus.done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    n_cmp++;
    if (dones != 0) begin
      n_bad++;
      $display("FAIL rst_mid done_count got=%0d exp=0", dones);
    end
    run_op(4'd3, 4'd3, 1'b0, "after_rst");
  endtask

  task automatic test_back_to_back();
    int gap;
    bit got;
    @(negedge clk);
    bus.A = 4'd9; bus.B = 4'd4; bus.C_in = 1'b1; bus.start = 1'b1;
    got = 0;
    for (int n = 0; n < TMO; n++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1;
        break;
      end
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL b2b first_timeout got=0 exp=1");
    end
    model(4'd9, 4'd4, 1'b1);
    check_outputs("b2b_first");
    bus.A = 4'd12; bus.B = 4'd6; bus.C_in = 1'b0;
    gap = 0; got = 0;
    for (int n = 0; n < TMO; n++) begin
      @(negedge clk);
      gap++;
      if (bus.done) begin
        got = 1;
        break;
      end
    end
    bus.start = 1'b0;
    n_cmp++;
    if (!got || gap != WIDTH + 2) begin
      n_bad++;
      $display("FAIL b2b spacing got=%0d exp=%0d", gap, WIDTH + 2);
    end
    model(4'd12, 4'd6, 1'b0);
    check_outputs("b2b_second");
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b idle_busy got=%b exp=0", bus.busy);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), "rand");
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.C_in  = 1'b0;
    rst_n     = 1'b0;
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
